// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU front end: opcodes, fetch FSM encoding
// and default widths.
package cpu_pkg;

   localparam int DEF_INSTR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH  = 4;
   localparam int DEF_ADDR_WIDTH  = 4;

   localparam logic [3:0] OP_NOP = 4'hC;
   localparam logic [3:0] OP_LDI = 4'hD;
   localparam logic [3:0] OP_RST = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FETCH     = 2'd1,
      ST_FETCH_IMM = 2'd2,
      ST_ISSUE     = 2'd3
   } ifu_state_e;

   function automatic logic is_ldi(input logic [3:0] op);
      return op == OP_LDI;
   endfunction

endpackage

// File: rtl/program_memory.sv
// Program store: 2**ADDR_WIDTH words, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a CPU reset.
module program_memory
   import cpu_pkg::*;
#(
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   we_i,
   input  logic [ADDR_WIDTH-1:0]  waddr_i,
   input  logic [INSTR_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0]  raddr_i,
   output logic [INSTR_WIDTH-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch_unit.sv
// CPU front end: program memory + PC, fetches opcodes (and the LDI immediate)
// and issues them to the decoder. Define IFU_BREAKPOINT_EN for PC breakpoints.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | stopped; program writes accepted; waits for RUN
// ST_FETCH     | read opcode at PC, PC+1
// ST_FETCH_IMM | read LDI immediate at PC, PC+1
// ST_ISSUE     | INSTR_VALID high; honour RESET_INSTR; continue or stop
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   RUN,
   input  logic                   PROG_WE,
   input  logic [ADDR_WIDTH-1:0]  PROG_ADDR,
   input  logic [INSTR_WIDTH-1:0] PROG_DATA,
   input  logic                   RESET_INSTR,
   output logic [INSTR_WIDTH-1:0] INSTRUCTION,
   output logic [DATA_WIDTH-1:0]  IMM,
   output logic                   INSTR_VALID,
   output logic [ADDR_WIDTH-1:0]  PC,
   output logic                   BUSY
`ifdef IFU_BREAKPOINT_EN
   ,
   input  logic [ADDR_WIDTH-1:0]  BKPT_ADDR,
   input  logic                   BKPT_ARM,
   output logic                   BKPT_HIT
`endif
);

   localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(OP_NOP);

   ifu_state_e             state_q;
   logic [ADDR_WIDTH-1:0]  pc_q;
   logic [ADDR_WIDTH-1:0]  pc_inc;
   logic [ADDR_WIDTH-1:0]  issue_pc_d;
   logic [INSTR_WIDTH-1:0] ir_q;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic [DATA_WIDTH-1:0]  imm_q;
   logic                   valid_q;
   logic                   busy_q;
   logic                   mem_we;
   logic [INSTR_WIDTH-1:0] mem_rdata;
   logic                   fetched_ldi;
`ifdef IFU_BREAKPOINT_EN
   logic                   bkpt_hit_q;
`endif

   // Writes only land while stopped so a running program never sees itself change.
   assign mem_we      = PROG_WE && !RESET && (state_q == ST_IDLE);
   assign pc_inc      = pc_q + ADDR_WIDTH'(1);
   assign issue_pc_d  = RESET_INSTR ? '0 : pc_q;
   assign fetched_ldi = (mem_rdata == INSTR_WIDTH'(OP_LDI));

   program_memory #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_program_memory (
      .clk_i   (CLK),
      .we_i    (mem_we),
      .waddr_i (PROG_ADDR),
      .wdata_i (PROG_DATA),
      .raddr_i (pc_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         ir_q       <= NOP_WORD;
         instr_q    <= NOP_WORD;
         imm_q      <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef IFU_BREAKPOINT_EN
         bkpt_hit_q <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (RUN) begin
                  state_q    <= ST_FETCH;
                  busy_q     <= 1'b1;
`ifdef IFU_BREAKPOINT_EN
                  bkpt_hit_q <= 1'b0;
`endif
               end
            end
            ST_FETCH: begin
               ir_q <= mem_rdata;
               pc_q <= pc_inc;
               if (fetched_ldi) begin
                  state_q <= ST_FETCH_IMM;
               end else begin
                  state_q <= ST_ISSUE;
                  instr_q <= mem_rdata;
                  valid_q <= 1'b1;
               end
            end
            ST_FETCH_IMM: begin
               imm_q   <= mem_rdata[DATA_WIDTH-1:0];
               pc_q    <= pc_inc;
               state_q <= ST_ISSUE;
               instr_q <= ir_q;
               valid_q <= 1'b1;
            end
            ST_ISSUE: begin
               pc_q <= issue_pc_d;
               if (!RUN) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
`ifdef IFU_BREAKPOINT_EN
               end else if (BKPT_ARM && (issue_pc_d == BKPT_ADDR)) begin
                  // Only checked here, so the first fetch after IDLE always proceeds.
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  bkpt_hit_q <= 1'b1;
`endif
               end else begin
                  state_q <= ST_FETCH;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign INSTRUCTION = instr_q;
   assign IMM         = imm_q;
   assign INSTR_VALID = valid_q;
   assign PC          = pc_q;
   assign BUSY        = busy_q;
`ifdef IFU_BREAKPOINT_EN
   assign BKPT_HIT    = bkpt_hit_q;
`endif

endmodule
